// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver (majority vote, false-start reject) with sticky status and RX FIFO.
// Latency: a word reaches rd_data two cycles after the mid+1 tick of its final stop bit; pops take effect next cycle.
// Backpressure: none on rx; a push into a full FIFO is dropped and flags overrun unless rd_en pops in the same cycle.
// Optional: define UART_RX_PARITY_EN to compile in the PARITY state and parity checker.
module uart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     divider,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 flush,
  input  logic                 rd_en,
  input  logic                 err_clr,
  input  logic [3:0]           irq_mask,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  output logic                 irq
);
  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_MLO  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_MHI  = SMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, rxs_q, rxs_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [SMP_W-1:0]       smp_q, smp_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0]   shr_q, shr_d;
  logic [BC_W-1:0]        bc_q, bc_d;
  logic                   two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic                   push_q, push_d, push_ferr_q, push_ferr_d;
  logic [DATA_BITS-1:0]   push_dat_q, push_dat_d;
  logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic                   ferr_q, ferr_d, ovr_q, ovr_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic                   tick, at_hi, at_end, vote, do_push, do_pop;
`ifdef UART_RX_PARITY_EN
  logic                   par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                   perr_acc_q, perr_acc_d, push_perr_q, push_perr_d;
  logic                   perr_q, perr_d;
`else
  logic                   unused_pmode;
  assign unused_pmode = ^parity_mode;
`endif

  // Synchroniser, tick/sample counters, vote capture and the receive state machine.
  always_comb begin
    sync1_d     = rx;
    rxs_d       = sync1_q;
    tick        = (cnt_q == divider);
    cnt_d       = tick ? '0 : cnt_q + DIV_W'(1);
    smp_d       = smp_q;
    if (tick) smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
    at_hi       = tick && (smp_q == SMP_MHI);
    at_end      = tick && (smp_q == SMP_LAST);
    s0_d        = (tick && smp_q == SMP_MLO) ? rxs_q : s0_q;
    s1_d        = (tick && smp_q == SMP_MID) ? rxs_q : s1_q;
    vote        = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    state_d     = state_q;
    shr_d       = shr_q;
    bc_d        = bc_q;
    two_stop_d  = two_stop_q;
    stop2_d     = stop2_q;
    ferr_acc_d  = ferr_acc_q;
    push_d      = 1'b0;
    push_dat_d  = push_dat_q;
    push_ferr_d = push_ferr_q;
`ifdef UART_RX_PARITY_EN
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    perr_acc_d  = perr_acc_q;
    push_perr_d = push_perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          // Frame format is frozen here so mid-frame register writes hit the next frame.
          smp_d      = '0;
          state_d    = S_START;
          bc_d       = '0;
          two_stop_d = stop_bits;
          stop2_d    = 1'b0;
          ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_en_d   = parity_mode[0] ^ parity_mode[1];
          par_odd_d  = parity_mode[1];
          perr_acc_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (at_hi && vote) state_d = S_IDLE;
        else if (at_end)   state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (at_hi) begin
          shr_d = {vote, shr_q[DATA_BITS-1:1]};
          bc_d  = bc_q + BC_W'(1);
        end
        if (at_end && bc_q == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_hi)  perr_acc_d = (^shr_q) ^ vote ^ par_odd_q;
        if (at_end) state_d    = S_STOP;
      end
`endif
      S_STOP: begin
        if (at_hi) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d    = 1'b1;
            ferr_acc_d = ferr_acc_q | !vote;
          end else begin
            // Final stop vote: hand the word off and re-arm start detection straight away.
            push_d      = 1'b1;
            push_dat_d  = shr_q;
            push_ferr_d = ferr_acc_q | !vote;
`ifdef UART_RX_PARITY_EN
            push_perr_d = perr_acc_q;
`endif
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data    = fifo_empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // FIFO pointers (flush wins) and sticky status (a set beats a same-cycle clear).
  always_comb begin
    do_pop  = rd_en && !fifo_empty;
    do_push = push_q && (!fifo_full || rd_en);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    ferr_d = (ferr_q && !err_clr) || (push_q && push_ferr_q);
    ovr_d  = (ovr_q && !err_clr) || (push_q && fifo_full && !rd_en && !flush);
`ifdef UART_RX_PARITY_EN
    perr_d = (perr_q && !err_clr) || (push_q && push_perr_q);
`endif
  end

  // FIFO storage; a push cancelled by flush never lands.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= push_dat_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      smp_q       <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      shr_q       <= '0;
      bc_q        <= '0;
      two_stop_q  <= 1'b0;
      stop2_q     <= 1'b0;
      ferr_acc_q  <= 1'b0;
      push_q      <= 1'b0;
      push_dat_q  <= '0;
      push_ferr_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      perr_acc_q  <= 1'b0;
      push_perr_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      cnt_q       <= cnt_d;
      smp_q       <= smp_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      shr_q       <= shr_d;
      bc_q        <= bc_d;
      two_stop_q  <= two_stop_d;
      stop2_q     <= stop2_d;
      ferr_acc_q  <= ferr_acc_d;
      push_q      <= push_d;
      push_dat_q  <= push_dat_d;
      push_ferr_q <= push_ferr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      perr_acc_q  <= perr_acc_d;
      push_perr_q <= push_perr_d;
      perr_q      <= perr_d;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign irq = |(irq_mask & {ovr_q, parity_error, ferr_q, !fifo_empty});
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: DATA_BITS=8, OVERSAMPLE=16, divider=3 (64-clk bit), FIFO_DEPTH=8.
// Frame vectors are table-driven; false start, glitch, overrun, flush and reset-mid-frame are hand sequences.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_ovs;
  localparam int DB      = 8;
  localparam int BIT_CYC = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [15:0]   divider = 16'd3;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop_bits = 1'b0, flush = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [3:0]    irq_mask = 4'h0;
  logic [DB-1:0] rd_data;
  logic          fifo_empty, fifo_full, framing_error, parity_error, overrun_error, irq;

  uart_rx_ovs #(.DATA_BITS(DB), .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .divider(divider), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .flush(flush), .rd_en(rd_en), .err_clr(err_clr), .irq_mask(irq_mask),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .framing_error(framing_error), .parity_error(parity_error),
    .overrun_error(overrun_error), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0, errors = 0;
  int   last_start = 0, full_rise_cyc = 0;
  logic prev_full = 1'b0;
  always @(negedge clk) begin
    if (fifo_full && !prev_full) full_rise_cyc = cyc;
    prev_full = fifo_full;
  end

  typedef struct {
    logic [7:0] data;  logic [1:0] pmode; logic two; logic has_par; logic par_val;
    logic s1; logic s2; logic [3:0] mask;
    logic [7:0] exp_data; logic exp_ferr; logic exp_perr; logic exp_irq;
  } vec_t;
  vec_t vt [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    rx = v;
    if (glitch) begin
      step(36); rx = ~v; step(4); rx = v; step(24);
    end else begin
      step(BIT_CYC);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pv,
                            input bit two, input logic s1, input logic s2, input int gbit);
    while (cyc % 4 != 0) step(1);
    last_start = cyc;
    send_bit(1'b0, 1'b0);
    for (int b = 0; b < DB; b++) send_bit(d[b], b == gbit);
    if (has_par) send_bit(pv, 1'b0);
    send_bit(s1, 1'b0);
    if (two) send_bit(s2, 1'b0);
    rx = 1'b1;
    step(BIT_CYC);
  endtask

  task automatic pop();
    rd_en = 1'b1; step(1); rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; step(1); err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int lat, s;
    logic [7:0] exp_q [$];
    //          data   pm     two   hp    pv    s1    s2    mask     exp    ferr  perr  irq
    vt[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 8'hA5, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 8'h03, 1'b0, PEN,  PEN };
    vt[3] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 8'h03, !PEN, 1'b0, 1'b0};
    vt[4] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 8'h03, !PEN, PEN,  PEN };
    vt[6] = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 8'h5A, 1'b1, 1'b0, 1'b1};
    vt[7] = '{8'h5A, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h5A, 1'b1, 1'b0, 1'b1};
    vt[8] = '{8'hC3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 8'hC3, 1'b0, 1'b0, 1'b0};

    // Reset values, with every interrupt source enabled.
    irq_mask = 4'hF;
    step(4); rst = 1'b0; step(2);
    chk8("reset.rd_data", rd_data, 8'h00);
    chk1("reset.empty", fifo_empty, 1'b1);
    chk1("reset.full", fifo_full, 1'b0);
    chk1("reset.ferr", framing_error, 1'b0);
    chk1("reset.perr", parity_error, 1'b0);
    chk1("reset.ovr", overrun_error, 1'b0);
    chk1("reset.irq", irq, 1'b0);

    // Frame table.
    for (int i = 0; i < 9; i++) begin
      parity_mode = vt[i].pmode;
      stop_bits   = vt[i].two;
      irq_mask    = vt[i].mask;
      send_frame(vt[i].data, vt[i].has_par, vt[i].par_val, vt[i].two, vt[i].s1, vt[i].s2, -1);
      chk8($sformatf("v%0d.rd_data", i), rd_data, vt[i].exp_data);
      chk1($sformatf("v%0d.empty", i), fifo_empty, 1'b0);
      chk1($sformatf("v%0d.ferr", i), framing_error, vt[i].exp_ferr);
      chk1($sformatf("v%0d.perr", i), parity_error, vt[i].exp_perr);
      chk1($sformatf("v%0d.ovr", i), overrun_error, 1'b0);
      chk1($sformatf("v%0d.irq", i), irq, vt[i].exp_irq);
      pop();
      chk1($sformatf("v%0d.empty_after_pop", i), fifo_empty, 1'b1);
      clear_errs();
      chk1($sformatf("v%0d.ferr_cleared", i), framing_error, 1'b0);
      chk1($sformatf("v%0d.perr_cleared", i), parity_error, 1'b0);
    end
    parity_mode = 2'b00; stop_bits = 1'b0;

    // rx low for only 4 ticks: must be rejected as a false start.
    irq_mask = 4'b0011;
    while (cyc % 4 != 0) step(1);
    rx = 1'b0; step(16); rx = 1'b1; step(200);
    chk1("false_start.empty", fifo_empty, 1'b1);
    chk1("false_start.ferr", framing_error, 1'b0);
    chk1("false_start.irq", irq, 1'b0);

    // One-tick high glitch across the middle vote sample of data bit 0 of 0x00.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk8("glitch.rd_data", rd_data, 8'h00);
    chk1("glitch.empty", fifo_empty, 1'b0);
    chk1("glitch.ferr", framing_error, 1'b0);
    pop();

    // Flush discards stored words.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk1("flush.empty_before", fifo_empty, 1'b0);
    flush = 1'b1; step(1); flush = 1'b0;
    chk1("flush.empty", fifo_empty, 1'b1);
    chk8("flush.rd_data", rd_data, 8'h00);

    // Fill the FIFO, overrun with 0x09, then push 0x0A with rd_en in the push cycle.
    irq_mask = 4'b1000;
    for (int v = 1; v <= 8; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk1("fill.full", fifo_full, 1'b1);
    chk1("fill.ovr", overrun_error, 1'b0);
    lat = full_rise_cyc - last_start;
    chk1("fill.push_latency_in_range", (lat > 576 && lat < 704), 1'b1);
    if (lat <= 576 || lat >= 704) lat = 640;
    send_frame(8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk1("overrun.ovr", overrun_error, 1'b1);
    chk1("overrun.full", fifo_full, 1'b1);
    chk1("overrun.irq", irq, 1'b1);
    chk8("overrun.head", rd_data, 8'h01);
    clear_errs();
    chk1("overrun.cleared", overrun_error, 1'b0);
    while (cyc % 4 != 0) step(1);
    s = cyc;
    fork
      send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      begin
        while (cyc < s + lat - 1) step(1);
        rd_en = 1'b1; step(1); rd_en = 1'b0;
      end
    join
    chk1("popush.ovr", overrun_error, 1'b0);
    chk1("popush.full", fifo_full, 1'b1);
    for (int v = 2; v <= 8; v++) exp_q.push_back(8'(v));
    exp_q.push_back(8'h0A);
    foreach (exp_q[k]) begin
      chk8($sformatf("drain%0d.rd_data", k), rd_data, exp_q[k]);
      pop();
    end
    chk1("drain.empty", fifo_empty, 1'b1);

    // Reset in the middle of 0xFF while the FIFO holds a word and an error is sticky.
    irq_mask = 4'hF;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    chk1("pre_reset.ferr", framing_error, 1'b1);
    chk1("pre_reset.empty", fifo_empty, 1'b0);
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      begin
        step(4 * BIT_CYC); rst = 1'b1; step(2); rst = 1'b0;
      end
    join
    chk8("midrst.rd_data", rd_data, 8'h00);
    chk1("midrst.empty", fifo_empty, 1'b1);
    chk1("midrst.full", fifo_full, 1'b0);
    chk1("midrst.ferr", framing_error, 1'b0);
    chk1("midrst.perr", parity_error, 1'b0);
    chk1("midrst.ovr", overrun_error, 1'b0);
    chk1("midrst.irq", irq, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    chk8("after_rst.rd_data", rd_data, 8'h3C);
    chk1("after_rst.empty", fifo_empty, 1'b0);
    chk1("after_rst.ferr", framing_error, 1'b0);
    chk1("after_rst.perr", parity_error, 1'b0);
    pop();
    chk1("after_rst.empty_after_pop", fifo_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
